// File: rtl/pfb_pipe_sequencer_pkg.sv
// Shared constants and types for the polyphase filter bank pipeline sequencer.
//   PHASE_WIDTH : commutator phase counter width (up to 2**PHASE_WIDTH phases)
//   PIPE_LAT    : ce-cycles from input accept to datapath result (MAC chain + round)
//   DATA_WIDTH  : datapath result width, I in the upper half and Q in the lower half
package pfb_pipe_sequencer_pkg;

  localparam int unsigned PHASE_WIDTH = 11;
  localparam int unsigned PIPE_LAT    = 8;
  localparam int unsigned DATA_WIDTH  = 32;

  // Rounded I/Q field positions inside a datapath result word.
  localparam int unsigned I_MSB = 31;
  localparam int unsigned I_LSB = 16;
  localparam int unsigned Q_MSB = 15;
  localparam int unsigned Q_LSB = 0;

  typedef logic [PHASE_WIDTH-1:0] phase_t;
  typedef logic [DATA_WIDTH-1:0]  data_t;

  // Side-band tag travelling alongside the datapath for each accepted sample.
  typedef struct packed {
    logic   valid;
    logic   last;
    phase_t phase;
  } pipe_tag_t;

  localparam int unsigned TAG_WIDTH = $bits(pipe_tag_t);

  // Next commutator phase: wrap at the end of the frame or on a resync.
  function automatic phase_t phase_advance(input phase_t phase,
                                           input phase_t last_phase,
                                           input logic   resync);
    if ((phase == last_phase) || resync) begin
      return '0;
    end
    return phase_t'(phase + 1'b1);
  endfunction

endpackage

// File: rtl/pfb_pipe_sequencer_if.sv
// Stream handshake bundle around the sequencer.
//   s_axis_tvalid/tlast : upstream sample valid and end-of-frame marker
//   s_axis_tready       : upstream ready (global clock enable)
//   m_axis_*            : result stream towards the FFT input buffer
// master : the sequencer side (drives s_axis_tready and all m_axis payload)
// slave  : the environment side (upstream source + downstream sink)
interface pfb_pipe_sequencer_if;
  import pfb_pipe_sequencer_pkg::*;

  logic   s_axis_tvalid;
  logic   s_axis_tready;
  logic   s_axis_tlast;

  data_t  m_axis_tdata;
  phase_t m_axis_tuser;
  logic   m_axis_tlast;
  logic   m_axis_tvalid;
  logic   m_axis_tready;

  modport master (
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tuser,
    output m_axis_tlast,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tuser,
    input  m_axis_tlast,
    input  m_axis_tvalid,
    output m_axis_tready
  );

endinterface

// File: rtl/pfb_pipe_sequencer_ce_delay.sv
// Clock-enable gated shift register, used to carry per-sample tags in step
// with the DSP pipeline so that the tail lines up with the datapath result.
//   clk, sync_reset : clock and synchronous active-high reset (clears all stages)
//   i_ce            : shift enable
//   i_data          : value entering stage 0
//   o_data          : value leaving the last stage (DEPTH ce-cycles later)
module pfb_pipe_sequencer_ce_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift chain; holds whenever the global enable is low.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_sr[i] <= '0;
      end
    end else if (i_ce) begin
      r_sr[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_data = r_sr[DEPTH-1];

endmodule

// File: rtl/pfb_pipe_sequencer.sv
// Pipeline sequencer for the polyphase filter bank MAC/round datapath.
// Owns the global clock enable, tracks the commutator phase, addresses the
// tap memory / coefficient ROM, delays valid/phase/last alongside the
// datapath and registers results onto a backpressured stream.
//   clk, sync_reset : clock, synchronous active-high reset
//   num_phases_m1   : phase count minus one, taken at frame boundaries only
//   axis            : upstream accept handshake + downstream result stream
//   ce              : global enable for every DSP CE pin and the tap memory
//   mem_wr_en       : tap delay memory write strobe (= upstream accept)
//   mem_addr        : tap memory / coefficient address (= current phase)
//   dp_data         : rounded datapath result, PIPE_LAT ce-cycles after accept
//   sync_err        : sticky, upstream tlast arrived off the last phase
module pfb_pipe_sequencer
  import pfb_pipe_sequencer_pkg::*;
(
  input  logic                       clk,
  input  logic                       sync_reset,
  input  phase_t                     num_phases_m1,
  pfb_pipe_sequencer_if.master       axis,
  output logic                       ce,
  output logic                       mem_wr_en,
  output phase_t                     mem_addr,
  input  data_t                      dp_data,
  output logic                       sync_err
);

  phase_t    r_phase;
  phase_t    r_last_phase;
  logic      r_sync_err;

  logic      r_tvalid;
  data_t     r_tdata;
  phase_t    r_tuser;
  logic      r_tlast;

  logic      w_ce;
  logic      w_accept;
  logic      w_frame_end;
  logic      w_resync;
  pipe_tag_t w_tag_in;
  pipe_tag_t w_tag_out;

  // The whole pipe advances only when the output register is empty or
  // draining; forced on in reset so the DSP chain keeps flushing.
  assign w_ce        = sync_reset | ~r_tvalid | axis.m_axis_tready;
  assign w_accept    = axis.s_axis_tvalid & w_ce & ~sync_reset;
  assign w_frame_end = (r_phase == r_last_phase);
  assign w_resync    = axis.s_axis_tlast & ~w_frame_end;

  // Commutator phase, per-frame phase count and sticky resync flag.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_phase      <= '0;
      r_last_phase <= num_phases_m1;
      r_sync_err   <= 1'b0;
    end else if (w_accept) begin
      r_phase <= phase_advance(r_phase, r_last_phase, w_resync);
      if (w_frame_end) begin
        r_last_phase <= num_phases_m1;
      end
      if (w_resync) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  // Tag captured at accept; last marks only a genuine end-of-frame phase,
  // so a resynced sample is emitted with last low.
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_accept;
    w_tag_in.last  = w_frame_end;
    w_tag_in.phase = r_phase;
  end

  pfb_pipe_sequencer_ce_delay #(
    .WIDTH (TAG_WIDTH),
    .DEPTH (PIPE_LAT)
  ) u_tag_delay (
    .clk        (clk),
    .sync_reset (sync_reset),
    .i_ce       (w_ce),
    .i_data     (w_tag_in),
    .o_data     (w_tag_out)
  );

  // Output register; payload only reloads on a valid tail so it stays
  // stable while the sink stalls.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
    end else if (w_ce) begin
      r_tvalid <= w_tag_out.valid;
      if (w_tag_out.valid) begin
        r_tdata <= dp_data;
        r_tuser <= w_tag_out.phase;
        r_tlast <= w_tag_out.last;
      end
    end
  end

  assign axis.s_axis_tready = w_ce;
  assign axis.m_axis_tvalid = r_tvalid;
  assign axis.m_axis_tdata  = r_tdata;
  assign axis.m_axis_tuser  = r_tuser;
  assign axis.m_axis_tlast  = r_tlast;

  assign ce        = w_ce;
  assign mem_wr_en = w_accept;
  assign mem_addr  = r_phase;
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_pfb_pipe_sequencer.sv
module tb_pfb_pipe_sequencer;
  import pfb_pipe_sequencer_pkg::*;

  localparam int unsigned REG_W  = 3 + DATA_WIDTH + PHASE_WIDTH;
  localparam int unsigned COMB_W = 3 + PHASE_WIDTH;

  logic   clk = 1'b0;
  logic   sync_reset = 1'b0;
  phase_t num_phases_m1 = phase_t'(7);
  logic   ce;
  logic   mem_wr_en;
  phase_t mem_addr;
  data_t  dp_data;
  logic   sync_err;

  pfb_pipe_sequencer_if axis_if ();

  pfb_pipe_sequencer dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .num_phases_m1 (num_phases_m1),
    .axis          (axis_if),
    .ce            (ce),
    .mem_wr_en     (mem_wr_en),
    .mem_addr      (mem_addr),
    .dp_data       (dp_data),
    .sync_err      (sync_err)
  );

  always #5 clk = ~clk;

  // External datapath stand-in: result appears PIPE_LAT ce-cycles after the sample.
  data_t s_data = '0;
  data_t dp_pipe [PIPE_LAT];
  always @(posedge clk) begin
    if (ce) begin
      dp_pipe[0] <= s_data;
      for (int i = 1; i < int'(PIPE_LAT); i++) dp_pipe[i] <= dp_pipe[i-1];
    end
  end
  assign dp_data = dp_pipe[PIPE_LAT-1];

  // Reference model: accepted samples age by one per enabled cycle and are
  // presented once they have seen PIPE_LAT+1 enabled cycles.
  typedef struct {
    data_t       data;
    phase_t      phase;
    logic        last;
    int unsigned age;
  } item_t;

  item_t  inflight [$];
  phase_t md_phase = '0;
  phase_t md_last_phase = '0;
  logic   md_err = 1'b0;
  logic   md_out_valid = 1'b0;
  data_t  md_out_data = '0;
  phase_t md_out_phase = '0;
  logic   md_out_last = 1'b0;

  int     checks = 0;
  int     errors = 0;
  int     hs_cnt = 0;
  int     acc_cnt = 0;
  logic   hs_now, hs_last;
  logic   exp_ce, exp_wr;
  phase_t exp_addr;
  logic   obs_ce, obs_tready, obs_wr;
  phase_t obs_addr;

  function automatic logic [REG_W-1:0] obs_reg_f();
    return {axis_if.m_axis_tvalid, axis_if.m_axis_tdata, axis_if.m_axis_tuser,
            axis_if.m_axis_tlast, sync_err};
  endfunction

  function automatic logic [REG_W-1:0] exp_reg_f();
    return {md_out_valid, md_out_data, md_out_phase, md_out_last, md_err};
  endfunction

  function automatic logic [COMB_W-1:0] obs_comb_f();
    return {obs_ce, obs_tready, obs_wr, obs_addr};
  endfunction

  function automatic logic [COMB_W-1:0] exp_comb_f();
    return {exp_ce, exp_ce, exp_wr, exp_addr};
  endfunction

  // One clock: drive inputs, sample combinational outputs, advance model, land on negedge.
  task automatic step(input logic rst, input logic tv, input logic tl, input logic tr);
    item_t it;
    sync_reset = rst;
    axis_if.s_axis_tvalid = tv;
    axis_if.s_axis_tlast  = tl;
    axis_if.m_axis_tready = tr;
    s_data[I_MSB:I_LSB] = 16'($urandom);
    s_data[Q_MSB:Q_LSB] = 16'($urandom);
    exp_ce   = rst | ~md_out_valid | tr;
    exp_wr   = tv & exp_ce & ~rst;
    exp_addr = md_phase;
    #1;
    obs_ce     = ce;
    obs_tready = axis_if.s_axis_tready;
    obs_wr     = mem_wr_en;
    obs_addr   = mem_addr;
    hs_now  = !rst && tr && (axis_if.m_axis_tvalid === 1'b1);
    hs_last = axis_if.m_axis_tlast;
    if (hs_now) hs_cnt++;
    if (exp_wr) acc_cnt++;
    @(posedge clk);
    if (rst) begin
      md_phase = '0; md_last_phase = num_phases_m1; md_err = 1'b0;
      inflight.delete();
      md_out_valid = 1'b0; md_out_data = '0; md_out_phase = '0; md_out_last = 1'b0;
    end else if (exp_ce) begin
      foreach (inflight[i]) inflight[i].age++;
      if (exp_wr) begin
        it.data = s_data; it.phase = md_phase;
        it.last = (md_phase == md_last_phase); it.age = 1;
        inflight.push_back(it);
        if (md_phase == md_last_phase) begin
          md_phase = '0; md_last_phase = num_phases_m1;
        end else if (tl) begin
          md_phase = '0; md_err = 1'b1;
        end else begin
          md_phase = phase_t'(md_phase + 1);
        end
      end
      if (inflight.size() != 0 && inflight[0].age == PIPE_LAT + 1) begin
        it = inflight.pop_front();
        md_out_valid = 1'b1; md_out_data = it.data;
        md_out_phase = it.phase; md_out_last = it.last;
      end else begin
        md_out_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    num_phases_m1 = phase_t'(7);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_ce !== 1'b1 || obs_tready !== 1'b1 || obs_wr !== 1'b0) begin
        errors++;
        $display("FAIL reset_ce cyc%0d: ce=%b tready=%b wr=%b, required 1 1 0", i, obs_ce, obs_tready, obs_wr);
      end
    end
    checks++;
    if (obs_reg_f() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", obs_reg_f());
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_comb_f() !== {1'b1, 1'b1, 1'b0, phase_t'(0)}) begin
      errors++;
      $display("FAIL reset_idle_comb: got %h, required %h", obs_comb_f(), {1'b1, 1'b1, 1'b0, phase_t'(0)});
    end
  endtask

  task automatic test_continuous();
    int first_valid = -1;
    int n_out = 0;
    num_phases_m1 = phase_t'(7);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 52; i++) begin
      step(1'b0, (i < 40), 1'b0, 1'b1);
      checks++;
      if (obs_comb_f() !== exp_comb_f()) begin
        errors++;
        $display("FAIL cont_comb i%0d: got %h, required %h", i, obs_comb_f(), exp_comb_f());
      end
      checks++;
      if (obs_reg_f() !== exp_reg_f()) begin
        errors++;
        $display("FAIL cont_out i%0d: got %h, required %h", i, obs_reg_f(), exp_reg_f());
      end
      if (axis_if.m_axis_tvalid === 1'b1) begin
        if (first_valid < 0) first_valid = i + 1;
        checks++;
        if (axis_if.m_axis_tuser !== phase_t'(n_out % 8) || axis_if.m_axis_tlast !== (n_out % 8 == 7)) begin
          errors++;
          $display("FAIL cont_seq n%0d: tuser=%0d tlast=%b, required %0d %b", n_out,
                   axis_if.m_axis_tuser, axis_if.m_axis_tlast, n_out % 8, (n_out % 8 == 7));
        end
        n_out++;
      end
    end
    checks++;
    if (first_valid != int'(PIPE_LAT) + 1) begin
      errors++;
      $display("FAIL cont_latency: got %0d, required %0d", first_valid, PIPE_LAT + 1);
    end
    checks++;
    if (n_out != 40) begin
      errors++;
      $display("FAIL cont_count: got %0d results, required 40", n_out);
    end
  endtask

  task automatic test_backpressure();
    logic [REG_W-1:0] snap;
    int hs0, acc0;
    num_phases_m1 = phase_t'(7);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    hs0 = hs_cnt; acc0 = acc_cnt;
    for (int i = 0; i < 52; i++) begin
      logic stall;
      stall = (i >= 14 && i < 19);
      if (i == 14) snap = obs_reg_f();
      step(1'b0, (i < 40), 1'b0, !stall);
      checks++;
      if (obs_comb_f() !== exp_comb_f() || obs_reg_f() !== exp_reg_f()) begin
        errors++;
        $display("FAIL bp_model i%0d: got %h/%h, required %h/%h", i, obs_comb_f(), obs_reg_f(),
                 exp_comb_f(), exp_reg_f());
      end
      if (stall) begin
        checks++;
        if (obs_ce !== 1'b0 || obs_tready !== 1'b0 || obs_reg_f() !== snap) begin
          errors++;
          $display("FAIL bp_hold i%0d: ce=%b tready=%b out=%h, required 0 0 %h", i, obs_ce, obs_tready,
                   obs_reg_f(), snap);
        end
      end
    end
    checks++;
    if (hs_cnt - hs0 != acc_cnt - acc0) begin
      errors++;
      $display("FAIL bp_count: delivered %0d, required %0d", hs_cnt - hs0, acc_cnt - acc0);
    end
  endtask

  task automatic test_resync();
    num_phases_m1 = phase_t'(7);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, (i < 16), (i == 3), 1'b1);
      checks++;
      if (obs_comb_f() !== exp_comb_f() || obs_reg_f() !== exp_reg_f()) begin
        errors++;
        $display("FAIL resync_model i%0d: got %h/%h, required %h/%h", i, obs_comb_f(), obs_reg_f(),
                 exp_comb_f(), exp_reg_f());
      end
      if (i == 3 || i == 29) begin
        checks++;
        if (sync_err !== 1'b1) begin
          errors++;
          $display("FAIL resync_err i%0d: sync_err=%b, required 1", i, sync_err);
        end
      end
      if (i == 4) begin
        checks++;
        if (obs_wr !== 1'b1 || obs_addr !== phase_t'(0)) begin
          errors++;
          $display("FAIL resync_phase: wr=%b addr=%0d, required 1 0", obs_wr, obs_addr);
        end
      end
    end
  endtask

  task automatic test_config();
    int lens [$];
    int len = 0;
    num_phases_m1 = phase_t'(7);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (i == 2) num_phases_m1 = phase_t'(3);
      step(1'b0, (i < 16), 1'b0, 1'b1);
      if (hs_now) begin
        len++;
        if (hs_last) begin lens.push_back(len); len = 0; end
      end
      checks++;
      if (obs_comb_f() !== exp_comb_f() || obs_reg_f() !== exp_reg_f()) begin
        errors++;
        $display("FAIL cfg_model i%0d: got %h/%h, required %h/%h", i, obs_comb_f(), obs_reg_f(),
                 exp_comb_f(), exp_reg_f());
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    if (hs_now) begin len++; if (hs_last) begin lens.push_back(len); len = 0; end end
    checks++;
    if (lens.size() != 3 || lens[0] != 8 || lens[1] != 4 || lens[2] != 4) begin
      errors++;
      $display("FAIL cfg_frames: %0d frames, first lengths %0d %0d %0d, required 3 frames 8 4 4",
               lens.size(), (lens.size() > 0) ? lens[0] : -1, (lens.size() > 1) ? lens[1] : -1,
               (lens.size() > 2) ? lens[2] : -1);
    end
  endtask

  task automatic test_reset_inflight();
    int hs0;
    num_phases_m1 = phase_t'(7);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, (i < 5), 1'b0, 1'b0);
      checks++;
      if (obs_comb_f() !== exp_comb_f() || obs_reg_f() !== exp_reg_f()) begin
        errors++;
        $display("FAIL rstfl_fill i%0d: got %h/%h, required %h/%h", i, obs_comb_f(), obs_reg_f(),
                 exp_comb_f(), exp_reg_f());
      end
    end
    checks++;
    if (axis_if.m_axis_tvalid !== 1'b1 || ce !== 1'b0) begin
      errors++;
      $display("FAIL rstfl_stalled: tvalid=%b ce=%b, required 1 0", axis_if.m_axis_tvalid, ce);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (axis_if.m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstfl_cleared: tvalid=%b, required 0", axis_if.m_axis_tvalid);
    end
    hs0 = hs_cnt;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (axis_if.m_axis_tvalid !== 1'b0 || obs_reg_f() !== exp_reg_f()) begin
        errors++;
        $display("FAIL rstfl_stale i%0d: got %h, required %h", i, obs_reg_f(), exp_reg_f());
      end
    end
    checks++;
    if (hs_cnt != hs0) begin
      errors++;
      $display("FAIL rstfl_count: %0d stale results, required 0", hs_cnt - hs0);
    end
  endtask

  task automatic test_random();
    int hs0, acc0;
    num_phases_m1 = phase_t'($urandom_range(0, 15));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    hs0 = hs_cnt; acc0 = acc_cnt;
    for (int i = 0; i < 420; i++) begin
      logic tv, tl, tr;
      if ($urandom_range(0, 49) == 0) num_phases_m1 = phase_t'($urandom_range(0, 15));
      tv = (i < 400) && ($urandom_range(0, 3) != 0);
      tl = ($urandom_range(0, 19) == 0);
      tr = (i >= 400) || ($urandom_range(0, 9) < 7);
      step(1'b0, tv, tl, tr);
      checks++;
      if (obs_comb_f() !== exp_comb_f() || obs_reg_f() !== exp_reg_f()) begin
        errors++;
        $display("FAIL rand_model i%0d: got %h/%h, required %h/%h", i, obs_comb_f(), obs_reg_f(),
                 exp_comb_f(), exp_reg_f());
      end
    end
    checks++;
    if (hs_cnt - hs0 != acc_cnt - acc0) begin
      errors++;
      $display("FAIL rand_count: delivered %0d, required %0d", hs_cnt - hs0, acc_cnt - acc0);
    end
  endtask

  initial begin
    axis_if.s_axis_tvalid = 1'b0;
    axis_if.s_axis_tlast  = 1'b0;
    axis_if.m_axis_tready = 1'b0;
    test_reset();
    test_continuous();
    test_backpressure();
    test_resync();
    test_config();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
